// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage.
//
// Contents:
//   slot_state_e : per-slot handshake state (EMPTY / BUSY / FULL)
//   MAX_STAGES   : largest supported chain length
//   occ_width()  : width of an occupancy counter for a given chain length
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } slot_state_e;

    localparam int MAX_STAGES = 8;

    // A chain of n slots holds 0..2n beats, so 2n+1 distinct counts.
    function automatic int occ_width(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One register slot with a 2-entry skid buffer.
//
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   flush                  : synchronous discard of held beats
//   in_data/in_valid       : upstream beat
//   in_ready               : slot can accept (pure decode of the state register)
//   out_data/out_valid     : downstream beat (out_data is the main register)
//   out_ready              : downstream accepts
//   occ                    : beats held in this slot (0, 1 or 2)
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       occ
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Flush only resets the state; data registers keep their contents, and
    // no write happens on a flush edge so an offered beat is never stored.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_valid) begin
                        main_d  = in_data;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (in_valid && out_ready) begin
                        main_d = in_data;
                    end else if (in_valid) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (out_ready) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // The skid entry only ever refills main; in_data is ignored.
                    if (out_ready) begin
                        main_d  = skid_q;
                        state_d = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // in_ready depends only on the state register, so a stalled consumer
    // never creates a combinational path back to the producer.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occ       = (state_q == FULL) ? 2'd2 :
                       (state_q == BUSY) ? 2'd1 : 2'd0;

endmodule

// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline register: STAGES skid-buffered slots in a chain.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous flush, empties every slot
//   in_data/in_valid    : upstream beat into slot 0
//   in_ready            : slot 0 can accept (registered)
//   out_data/out_valid  : downstream beat from the last slot
//   out_ready           : downstream accepts
//   occupancy           : total beats held across all slots
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 64,
    parameter int               STAGES    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [WIDTH-1:0]               in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [occ_width(STAGES)-1:0]   occupancy
);

    localparam int OCC_W = occ_width(STAGES);

    // Link k sits in front of slot k; link STAGES is the downstream port.
    logic [WIDTH-1:0] link_data  [STAGES+1];
    logic             link_valid [STAGES+1];
    logic             link_ready [STAGES+1];
    logic [1:0]       slot_occ   [STAGES];
    logic [OCC_W-1:0] occ_sum;

    assign link_data[0]       = in_data;
    assign link_valid[0]      = in_valid;
    assign in_ready           = link_ready[0];
    assign out_data           = link_data[STAGES];
    assign out_valid          = link_valid[STAGES];
    assign link_ready[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_slot
        pipe_skid_slot #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .in_data   (link_data[k]),
            .in_valid  (link_valid[k]),
            .in_ready  (link_ready[k]),
            .out_data  (link_data[k+1]),
            .out_valid (link_valid[k+1]),
            .out_ready (link_ready[k+1]),
            .occ       (slot_occ[k])
        );
    end

    // Occupancy is derived from slot states rather than a separate counter,
    // so it cannot drift from what the slots actually hold.
    always_comb begin
        occ_sum = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ_sum = occ_sum + OCC_W'(slot_occ[k]);
        end
    end

    assign occupancy = occ_sum;

endmodule
